// File: rtl/branch_resolve_id.sv
// Purpose: ID-stage branch resolver. It stalls or forwards the operands, evaluates the condition, flags a misprediction,
//          updates the 2-bit BHT and keeps resolution statistics.
// Latency: stall_ID/redirect/redirect_pc and pred_taken_IF are combinational (0 cycles). The BHT and counters update on the resolve/stall edge.
// Backpressure: stall_ID holds PC/IF/ID while the branch operand is not ready. The branch resolves exactly once, on its first unstalled cycle.
module branch_resolve_id #(
    parameter int IDX_W = 6,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_IF,
    output logic            pred_taken_IF,
    input  logic            valid_ID,
    input  logic [2:0]      op_ID,
    input  logic [2:0]      funct3_ID,
    input  logic [XLEN-1:0] pc_ID,
    input  logic            pred_taken_ID,
    input  logic [XLEN-1:0] branch_target_ID,
    input  logic [4:0]      rs1_ID,
    input  logic [4:0]      rs2_ID,
    input  logic [4:0]      rd_MEM,
    input  logic [XLEN-1:0] rs1_data_ID,
    input  logic [XLEN-1:0] rs2_data_ID,
    input  logic [XLEN-1:0] fwd_data_MEM,
    input  logic            ld_MEM,
    input  logic            th1,
    input  logic            th2,
    output logic            stall_ID,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt,
    output logic [31:0]     stall_cnt
);

    localparam int          BHT_N   = 1 << IDX_W;
    localparam logic [2:0]  OP_BR   = 3'b110;
    localparam logic [2:0]  F3_BEQ  = 3'b000;
    localparam logic [2:0]  F3_BNE  = 3'b001;
    localparam logic [2:0]  F3_BLT  = 3'b100;
    localparam logic [2:0]  F3_BGE  = 3'b101;
    localparam logic [2:0]  F3_BLTU = 3'b110;
    localparam logic [2:0]  F3_BGEU = 3'b111;

    // Branch history table: one 2-bit saturating counter per word-aligned PC slot
    logic [1:0]  r_bht [BHT_N];
    logic [31:0] r_branch_cnt;
    logic [31:0] r_mispred_cnt;
    logic [31:0] r_stall_cnt;

    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_upd_idx;
    logic             w_f3_legal;
    logic             w_br;
    logic             w_stall;
    logic             w_resolve;
    logic             w_fwd_a;
    logic             w_fwd_b;
    logic [XLEN-1:0]  w_op_a;
    logic [XLEN-1:0]  w_op_b;
    logic             w_taken;
    logic             w_mispred;
    logic             w_redirect;
    logic [XLEN-1:0]  w_pc_plus4;
    logic             w_unused_pc_bits;

    assign w_if_idx  = pc_IF[IDX_W+1:2];
    assign w_upd_idx = pc_ID[IDX_W+1:2];

    // The high PC bits and the byte offset do not take part in the BHT lookup
    assign w_unused_pc_bits = ^{pc_IF[XLEN-1:IDX_W+2], pc_IF[1:0]};

    // funct3 010/011 are not branch encodings: the branch is treated as absent
    assign w_f3_legal = (funct3_ID != 3'b010) && (funct3_ID != 3'b011);
    assign w_br       = valid_ID && (op_ID == OP_BR) && w_f3_legal;

    // An EX producer is never ready in ID. A load in MEM is ready only after WB writes through the register file.
    assign w_stall   = w_br && (th1 || (th2 && ld_MEM));
    assign w_resolve = w_br && !w_stall;

    // Forward an ALU result from MEM. x0 is never forwarded because it is hard-wired to zero.
    assign w_fwd_a = th2 && (rs1_ID == rd_MEM) && (rd_MEM != 5'd0);
    assign w_fwd_b = th2 && (rs2_ID == rd_MEM) && (rd_MEM != 5'd0);
    assign w_op_a  = w_fwd_a ? fwd_data_MEM : rs1_data_ID;
    assign w_op_b  = w_fwd_b ? fwd_data_MEM : rs2_data_ID;

    // Evaluate the branch condition on the selected operands
    always_comb begin
        w_taken = 1'b0;
        case (funct3_ID)
            F3_BEQ:  w_taken = (w_op_a == w_op_b);
            F3_BNE:  w_taken = (w_op_a != w_op_b);
            F3_BLT:  w_taken = ($signed(w_op_a) <  $signed(w_op_b));
            F3_BGE:  w_taken = ($signed(w_op_a) >= $signed(w_op_b));
            F3_BLTU: w_taken = (w_op_a <  w_op_b);
            F3_BGEU: w_taken = (w_op_a >= w_op_b);
            default: w_taken = 1'b0;
        endcase
    end

    assign w_mispred  = (w_taken != pred_taken_ID);
    assign w_redirect = w_resolve && w_mispred;
    assign w_pc_plus4 = pc_ID + {{(XLEN-3){1'b0}}, 3'b100};

    assign stall_ID    = w_stall;
    assign redirect    = w_redirect;
    assign redirect_pc = w_taken ? branch_target_ID : w_pc_plus4;

    // The prediction reads the pre-edge table, so a same-index update shows up from the next cycle
    assign pred_taken_IF = !rst && r_bht[w_if_idx][1];

    // BHT: reset to weakly not-taken, then train saturating on each resolved branch
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_N; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else if (w_resolve) begin
            if (w_taken) begin
                if (r_bht[w_upd_idx] != 2'b11) begin
                    r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'b01;
                end
            end else begin
                if (r_bht[w_upd_idx] != 2'b00) begin
                    r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'b01;
                end
            end
        end
    end

    // Statistics counters saturate at all-ones so long runs never alias to small values
    always_ff @(posedge clk) begin
        if (rst) begin
            r_branch_cnt  <= 32'd0;
            r_mispred_cnt <= 32'd0;
            r_stall_cnt   <= 32'd0;
        end else begin
            if (w_resolve && (r_branch_cnt != 32'hFFFF_FFFF)) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (w_redirect && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
            if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign branch_cnt  = r_branch_cnt;
    assign mispred_cnt = r_mispred_cnt;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_branch_resolve_id.sv
// Purpose: directed check of branch_resolve_id covering prediction, resolution, stall/forward, BHT saturation and reset.
// Latency: inputs are driven 1 time unit after posedge. Combinational outputs are checked 1 unit later, and state just after the edge.
// Backpressure: stall_ID is checked per cycle against hand-computed hazard sequences.
module tb_branch_resolve_id;

    logic        clk;
    logic        rst;
    logic [31:0] pc_IF;
    logic        pred_taken_IF;
    logic        valid_ID;
    logic [2:0]  op_ID;
    logic [2:0]  funct3_ID;
    logic [31:0] pc_ID;
    logic        pred_taken_ID;
    logic [31:0] branch_target_ID;
    logic [4:0]  rs1_ID;
    logic [4:0]  rs2_ID;
    logic [4:0]  rd_MEM;
    logic [31:0] rs1_data_ID;
    logic [31:0] rs2_data_ID;
    logic [31:0] fwd_data_MEM;
    logic        ld_MEM;
    logic        th1;
    logic        th2;
    logic        stall_ID;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;
    logic [31:0] stall_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    branch_resolve_id #(.IDX_W(6), .XLEN(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc_IF            (pc_IF),
        .pred_taken_IF    (pred_taken_IF),
        .valid_ID         (valid_ID),
        .op_ID            (op_ID),
        .funct3_ID        (funct3_ID),
        .pc_ID            (pc_ID),
        .pred_taken_ID    (pred_taken_ID),
        .branch_target_ID (branch_target_ID),
        .rs1_ID           (rs1_ID),
        .rs2_ID           (rs2_ID),
        .rd_MEM           (rd_MEM),
        .rs1_data_ID      (rs1_data_ID),
        .rs2_data_ID      (rs2_data_ID),
        .fwd_data_MEM     (fwd_data_MEM),
        .ld_MEM           (ld_MEM),
        .th1              (th1),
        .th2              (th2),
        .stall_ID         (stall_ID),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .branch_cnt       (branch_cnt),
        .mispred_cnt      (mispred_cnt),
        .stall_cnt        (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present a branch with no hazards; callers override hazard fields before settling
    task automatic drive(input logic [2:0] f3, input logic [31:0] pc, input logic pred,
                         input logic [31:0] tgt, input logic [31:0] a, input logic [31:0] b);
        valid_ID         = 1'b1;
        op_ID            = 3'b110;
        funct3_ID        = f3;
        pc_ID            = pc;
        pred_taken_ID    = pred;
        branch_target_ID = tgt;
        rs1_data_ID      = a;
        rs2_data_ID      = b;
        rs1_ID           = 5'd1;
        rs2_ID           = 5'd2;
        rd_MEM           = 5'd0;
        fwd_data_MEM     = 32'd0;
        ld_MEM           = 1'b0;
        th1              = 1'b0;
        th2              = 1'b0;
    endtask

    logic bne_pred   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic bne_redir  [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic bne_predif [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        rst = 1'b1;
        pc_IF = 32'h40;
        drive(3'b000, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
        valid_ID = 1'b0;
        cyc();
        cyc();
        chk("rst_pred_if", {31'd0, pred_taken_IF}, 32'd0);
        chk("rst_branch_cnt", branch_cnt, 32'd0);
        chk("rst_mispred_cnt", mispred_cnt, 32'd0);
        chk("rst_stall_cnt", stall_cnt, 32'd0);
        rst = 1'b0;

        // Taken BEQ, predicted not-taken
        drive(3'b000, 32'h40, 1'b0, 32'h80, 32'd5, 32'd5);
        #1;
        chk("beq_redirect", {31'd0, redirect}, 32'd1);
        chk("beq_redirect_pc", redirect_pc, 32'h80);
        chk("beq_stall", {31'd0, stall_ID}, 32'd0);
        chk("beq_pred_if_old", {31'd0, pred_taken_IF}, 32'd0);
        cyc();
        chk("beq_mispred_cnt", mispred_cnt, 32'd1);
        chk("beq_branch_cnt", branch_cnt, 32'd1);
        chk("beq_pred_if_new", {31'd0, pred_taken_IF}, 32'd1);

        // Train the entry to 11
        drive(3'b000, 32'h40, 1'b1, 32'h80, 32'd5, 32'd5);
        #1;
        chk("beq2_redirect", {31'd0, redirect}, 32'd0);
        cyc();
        chk("beq2_pred_if", {31'd0, pred_taken_IF}, 32'd1);

        // Not-taken BNE four times: 11->10->01->00->00
        for (int i = 0; i < 4; i++) begin
            drive(3'b001, 32'h40, bne_pred[i], 32'h80, 32'd5, 32'd5);
            #1;
            chk($sformatf("bne%0d_redirect", i), {31'd0, redirect}, {31'd0, bne_redir[i]});
            chk($sformatf("bne%0d_redirect_pc", i), redirect_pc, 32'h44);
            cyc();
            chk($sformatf("bne%0d_pred_if", i), {31'd0, pred_taken_IF}, {31'd0, bne_predif[i]});
        end
        chk("bne_branch_cnt", branch_cnt, 32'd6);
        chk("bne_mispred_cnt", mispred_cnt, 32'd3);

        // Taken from saturated 00 must only reach 01
        drive(3'b000, 32'h40, 1'b0, 32'h80, 32'd5, 32'd5);
        #1;
        chk("sat_redirect", {31'd0, redirect}, 32'd1);
        cyc();
        chk("sat_pred_if", {31'd0, pred_taken_IF}, 32'd0);

        // Signed vs unsigned compares of -1 and 1
        drive(3'b100, 32'h100, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'd1);
        #1;
        chk("blt_redirect", {31'd0, redirect}, 32'd1);
        chk("blt_redirect_pc", redirect_pc, 32'h200);
        cyc();
        drive(3'b110, 32'h100, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'd1);
        #1;
        chk("bltu_redirect", {31'd0, redirect}, 32'd0);
        chk("bltu_redirect_pc", redirect_pc, 32'h104);
        cyc();
        drive(3'b101, 32'h100, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'd1);
        #1;
        chk("bge_redirect", {31'd0, redirect}, 32'd0);
        cyc();
        drive(3'b111, 32'h100, 1'b0, 32'h200, 32'hFFFF_FFFF, 32'd1);
        #1;
        chk("bgeu_redirect", {31'd0, redirect}, 32'd1);
        chk("bgeu_redirect_pc", redirect_pc, 32'h200);
        cyc();
        chk("cmp_branch_cnt", branch_cnt, 32'd11);
        chk("cmp_mispred_cnt", mispred_cnt, 32'd6);

        // Illegal funct3 behaves as no branch
        drive(3'b010, 32'h100, 1'b1, 32'h200, 32'd5, 32'd5);
        th1 = 1'b1;
        #1;
        chk("ill_stall", {31'd0, stall_ID}, 32'd0);
        chk("ill_redirect", {31'd0, redirect}, 32'd0);
        cyc();
        chk("ill_branch_cnt", branch_cnt, 32'd11);
        chk("ill_stall_cnt", stall_cnt, 32'd0);

        // ALU producer: one stall, then MEM forward on rs1
        drive(3'b000, 32'h80, 1'b0, 32'h300, 32'd99, 32'd7);
        rs1_ID = 5'd3;
        rs2_ID = 5'd4;
        th1 = 1'b1;
        #1;
        chk("alu_c1_stall", {31'd0, stall_ID}, 32'd1);
        chk("alu_c1_redirect", {31'd0, redirect}, 32'd0);
        cyc();
        chk("alu_c1_branch_cnt", branch_cnt, 32'd11);
        th1 = 1'b0;
        th2 = 1'b1;
        rd_MEM = 5'd3;
        fwd_data_MEM = 32'd7;
        #1;
        chk("alu_c2_stall", {31'd0, stall_ID}, 32'd0);
        chk("alu_c2_redirect", {31'd0, redirect}, 32'd1);
        chk("alu_c2_redirect_pc", redirect_pc, 32'h300);
        cyc();
        chk("alu_stall_cnt", stall_cnt, 32'd1);
        chk("alu_branch_cnt", branch_cnt, 32'd12);
        chk("alu_mispred_cnt", mispred_cnt, 32'd7);

        // Load producer: two stalls, resolve from register file
        drive(3'b000, 32'h84, 1'b0, 32'h400, 32'd99, 32'd7);
        rs1_ID = 5'd3;
        rs2_ID = 5'd4;
        th1 = 1'b1;
        #1;
        chk("ld_c1_stall", {31'd0, stall_ID}, 32'd1);
        cyc();
        th1 = 1'b0;
        th2 = 1'b1;
        ld_MEM = 1'b1;
        rd_MEM = 5'd3;
        fwd_data_MEM = 32'd55;
        #1;
        chk("ld_c2_stall", {31'd0, stall_ID}, 32'd1);
        chk("ld_c2_redirect", {31'd0, redirect}, 32'd0);
        cyc();
        chk("ld_c2_branch_cnt", branch_cnt, 32'd12);
        th2 = 1'b0;
        ld_MEM = 1'b0;
        rd_MEM = 5'd0;
        rs1_data_ID = 32'd7;
        #1;
        chk("ld_c3_stall", {31'd0, stall_ID}, 32'd0);
        chk("ld_c3_redirect", {31'd0, redirect}, 32'd1);
        cyc();
        chk("ld_stall_cnt", stall_cnt, 32'd3);
        chk("ld_branch_cnt", branch_cnt, 32'd13);

        // rd_MEM == x0 must never forward
        drive(3'b000, 32'h88, 1'b0, 32'h500, 32'd0, 32'd0);
        rs1_ID = 5'd0;
        th2 = 1'b1;
        fwd_data_MEM = 32'd9;
        #1;
        chk("x0_stall", {31'd0, stall_ID}, 32'd0);
        chk("x0_redirect", {31'd0, redirect}, 32'd1);
        cyc();
        chk("x0_mispred_cnt", mispred_cnt, 32'd9);

        // Reset during a stall abandons the branch
        drive(3'b000, 32'h40, 1'b0, 32'h80, 32'd5, 32'd5);
        th1 = 1'b1;
        #1;
        chk("rs_stall", {31'd0, stall_ID}, 32'd1);
        cyc();
        rst = 1'b1;
        #1;
        chk("rs_stall_in_reset", {31'd0, stall_ID}, 32'd1);
        cyc();
        th1 = 1'b0;
        #1;
        chk("rs_redirect_in_reset", {31'd0, redirect}, 32'd1);
        cyc();
        chk("rs_branch_cnt", branch_cnt, 32'd0);
        chk("rs_mispred_cnt", mispred_cnt, 32'd0);
        chk("rs_stall_cnt", stall_cnt, 32'd0);
        chk("rs_pred_if", {31'd0, pred_taken_IF}, 32'd0);
        rst = 1'b0;

        // Same-index read at update edge returns the old value
        drive(3'b000, 32'h40, 1'b0, 32'h80, 32'd5, 32'd5);
        #1;
        chk("same_pred_if_old", {31'd0, pred_taken_IF}, 32'd0);
        cyc();
        chk("same_pred_if_new", {31'd0, pred_taken_IF}, 32'd1);

        // Different-index lookup is independent of the update
        pc_IF = 32'h44;
        drive(3'b001, 32'h40, 1'b1, 32'h80, 32'd5, 32'd5);
        #1;
        chk("diff_pred_if", {31'd0, pred_taken_IF}, 32'd0);
        chk("diff_redirect", {31'd0, redirect}, 32'd1);
        cyc();
        chk("diff_pred_if_after", {31'd0, pred_taken_IF}, 32'd0);
        pc_IF = 32'h40;
        valid_ID = 1'b0;
        #1;
        chk("diff_pred_if_40", {31'd0, pred_taken_IF}, 32'd0);
        chk("end_branch_cnt", branch_cnt, 32'd2);
        chk("end_mispred_cnt", mispred_cnt, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/branch_resolve_id.md
# branch_resolve_id

ID-stage branch resolution unit for the two-bit-predictor pipeline. It sits directly downstream of the ID forwarding detector and consumes its `th1`/`th2` hazard flags. It stalls or forwards branch operands, evaluates the branch condition, and compares the outcome with the IF-stage prediction. It drives the redirect/flush, updates its 2-bit saturating branch history table (BHT), and keeps resolution statistics.

## Interface
Parameters:
- `IDX_W`, default 6: BHT index width; 2^IDX_W entries, indexed by pc[IDX_W+1:2].
- `XLEN`, default 32: data and PC width.

Ports (clock and reset first):
- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pc_IF` in XLEN: fetch PC, used for the BHT lookup.
- `pred_taken_IF` out 1: BHT prediction for `pc_IF`, counter bit 1.
- `valid_ID` in 1: ID holds a live instruction.
- `op_ID` in 3: opcode class; 3'b110 means branch.
- `funct3_ID` in 3: branch condition.
- `pc_ID` in XLEN: PC of the ID instruction.
- `pred_taken_ID` in 1: prediction carried down from IF.
- `branch_target_ID` in XLEN: pc_ID + B-immediate.
- `rs1_ID` in 5, `rs2_ID` in 5: source registers.
- `rd_MEM` in 5: destination register in MEM.
- `rs1_data_ID` in XLEN, `rs2_data_ID` in XLEN: register-file read data, write-through.
- `fwd_data_MEM` in XLEN: ALU result in MEM.
- `ld_MEM` in 1: MEM instruction is a load.
- `th1` in 1: producer in EX (from forwarding detector).
- `th2` in 1: producer in MEM (from forwarding detector).
- `stall_ID` out 1: hold PC/IF/ID, bubble into EX.
- `redirect` out 1: one-cycle flush of IF and fetch from `redirect_pc`.
- `redirect_pc` out XLEN: correct next PC.
- `branch_cnt` out 32: resolved branches.
- `mispred_cnt` out 32: mispredicted branches.
- `stall_cnt` out 32: branch stall cycles.

## Operation
- `br = valid_ID && op_ID==3'b110`. funct3 values 010 and 011 are illegal: `br` is forced low (no stall, no update, no count).
- Stall: `stall_ID = br && (th1 || (th2 && ld_MEM))`.
  - th1: the EX producer's result is not ready.
  - th2 with ld_MEM: the load data is not ready until WB, when it is taken from the register file via write-through.
  - th1 has priority over th2.
- Operand select when not stalled:
  - opA = fwd_data_MEM if th2 && rs1_ID==rd_MEM && rd_MEM!=0, else rs1_data_ID.
  - opB uses the same rule with rs2.
- Resolve cycle: `br && !stall_ID`. Taken condition by funct3:
  - 000 BEQ, 001 BNE.
  - 100 BLT, 101 BGE: signed compare.
  - 110 BLTU, 111 BGEU: unsigned compare.
- `mispred = taken != pred_taken_ID`. `redirect = resolve && mispred`.
- `redirect_pc` = branch_target_ID if taken, else pc_ID+4 (mod 2^XLEN). It is don't-care when redirect is low.
- BHT update at the resolve edge: entry pc_ID[IDX_W+1:2] increments if taken, decrements if not. It saturates at 2'b11 and 2'b00.
- Counters are 32-bit, saturate at all-ones, and never wrap.
  - `branch_cnt` +1 per resolve.
  - `mispred_cnt` +1 per redirect.
  - `stall_cnt` +1 per cycle with stall_ID high.

## Timing
- Reset, held for one or more edges:
  - All BHT entries become 2'b01 (weakly not-taken).
  - All counters become 0.
  - `pred_taken_IF` reads 0.
  - stall_ID, redirect and redirect_pc follow their inputs combinationally, with no registered state in their path.
- `pred_taken_IF` is combinational from `pc_IF` and the BHT.
  - If IF reads the same index being updated that edge, it returns the pre-update value. The new value is visible from the next cycle.
- `stall_ID`, `redirect` and `redirect_pc` are combinational with zero latency. The BHT and counters update on the edge ending the resolve/stall cycle.
- Load-use on a branch: 2 stall cycles.
  - Cycle 1: th1.
  - Cycle 2: th2 with ld_MEM.
  - Cycle 3: resolve using the register file.
- ALU producer in EX: 1 stall cycle, then resolve with the MEM forward.
- A branch is resolved exactly once. A stalled branch never updates the BHT or branch_cnt.
- Reset asserted mid-stall abandons the branch: no update, no count.
- Simultaneous resolve and IF lookup of different indices are independent.

## Test plan
- After reset, pc_IF=0x40 gives pred_taken_IF=0. BEQ at pc_ID=0x40 with equal operands and pred_taken_ID=0 gives redirect=1, redirect_pc=branch_target_ID, mispred_cnt=1. The next cycle gives pred_taken_IF=1 for 0x40.
- The same not-taken branch three times from counter state 11 moves the entry 11→10→01→00, then saturates at 00. pred_taken_IF flips to 0 after the second update.
- BLT with rs1=x5=-1 (0xFFFFFFFF), rs2=1 is taken. BLTU with the same operands is not taken, and with pred_taken_ID=0 gives no redirect and redirect_pc=pc_ID+4.
- Branch with th1=1 for one cycle, then th2=1, ld_MEM=0, rd_MEM=rs1_ID=x3, fwd_data_MEM=7, rs2 data 7, BEQ:
  - stall_ID is high for exactly 1 cycle, then resolves taken.
  - stall_cnt=1, branch_cnt=1.
- Load producer: th1, then th2 with ld_MEM=1 gives 2 stall cycles, with resolve in cycle 3 from rs1_data_ID. rd_MEM=0 with th2 must not forward.
- Reset asserted during a stall: no counter or BHT change. Same-index IF read at the update edge returns the old prediction.
